fetch_controller: RTL and testbench

FETCH_CONTROLLER -- requirements
Module: fetch_controller

---
 rtl/fetch_controller_if.sv | 29 ++
 rtl/fetch_controller.sv | 132 +++++++++++++
 tb/tb_fetch_controller.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_controller_if.sv
// Bus bundle between the fetch controller, instruction memory, execute
// (redirect) and decode. The fetch side uses the master view; the environment
// (memory/decode/execute models) uses the slave view.
interface fetch_controller_if;
  // redirect from execute
  logic        redirect;
  logic [63:0] redirect_pc;
  // instruction memory request/response
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  // decode side
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] PC_out;
  logic        inst_ready;

  modport master (
    input  redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
    output imem_req, imem_addr, inst_valid, inst, PC_out
  );

  modport slave (
    output redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
    input  imem_req, imem_addr, inst_valid, inst, PC_out
  );
endinterface

// File: rtl/fetch_controller.sv
// Instruction fetch controller: issues one instruction-memory request at a
// time, collects responses into a small FIFO toward decode, and handles
// redirects from execute by flushing the FIFO and discarding any response
// still in flight for the old path.
module fetch_controller #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          DEPTH    = 2
) (
  input logic                clk,
  input logic                reset,
  fetch_controller_if.master bus
);

  localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int            CW   = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  // IDLE: buffer full, REQ: request on the bus, WAIT: granted and awaiting
  // data, DROP: granted request belongs to a redirected-away path.
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

  state_t        state_reg, state_next;
  logic [63:0]   fetch_pc_reg;
  logic [63:0]   req_pc_reg;
  logic [CW-1:0] count_reg, count_next;
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [63:0]   pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];

  logic granted;
  logic push;
  logic pop;

  // Events of this cycle; a redirect suppresses every buffer update.
  always_comb begin
    granted = (state_reg == REQ) && bus.imem_gnt;
    push    = (state_reg == WAIT) && bus.imem_rvalid && !bus.redirect;
    pop     = (count_reg != '0) && bus.inst_ready && !bus.redirect;
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; redirect is evaluated first in every state.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.redirect || (count_reg < FULL)) state_next = REQ;
      end
      REQ: begin
        if (bus.redirect)      state_next = bus.imem_gnt ? DROP : REQ;
        else if (bus.imem_gnt) state_next = WAIT;
      end
      WAIT: begin
        if (bus.redirect)         state_next = bus.imem_rvalid ? REQ : DROP;
        else if (bus.imem_rvalid) state_next = (count_next < FULL) ? REQ : IDLE;
      end
      DROP: begin
        // The stale response retires the outstanding request even if another
        // redirect lands in the same cycle; waiting on would never end.
        if (bus.imem_rvalid) state_next = REQ;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic: request follows the state, head of the FIFO goes to decode.
  always_comb begin
    bus.imem_req   = (state_reg == REQ);
    bus.imem_addr  = fetch_pc_reg;
    bus.inst_valid = (count_reg != '0);
    bus.inst       = 32'h0;
    bus.PC_out     = 64'h0;
    if (count_reg != '0) begin
      bus.inst   = inst_mem[rd_ptr_reg];
      bus.PC_out = pc_mem[rd_ptr_reg];
    end
  end

  // Fetch and in-flight PC: redirect overrides, otherwise advance on grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_reg <= RESET_PC;
      req_pc_reg   <= 64'h0;
    end else if (bus.redirect) begin
      fetch_pc_reg <= bus.redirect_pc;
    end else if (granted) begin
      req_pc_reg   <= fetch_pc_reg;
      fetch_pc_reg <= fetch_pc_reg + 64'd4;
    end
  end

  // FIFO occupancy and pointers; redirect empties the FIFO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else if (bus.redirect) begin
      count_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      count_reg <= count_next;
      if (push) wr_ptr_reg <= (wr_ptr_reg == LAST) ? '0 : wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= (rd_ptr_reg == LAST) ? '0 : rd_ptr_reg + PW'(1);
    end
  end

  // FIFO storage; contents are only observed while counted, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_reg]   <= req_pc_reg;
      inst_mem[wr_ptr_reg] <= bus.imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed scenarios followed by random traffic,
// all checked against a transaction-level model (expected fetch address, one
// pending memory transaction, and a queue of delivered instructions).
module tb_fetch_controller;

  localparam logic [63:0] RESET_PC = 64'h0;
  localparam int          DEPTH    = 2;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] ins;
  } ent_t;

  logic clk;
  logic reset;
  fetch_controller_if ifc ();

  fetch_controller #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model
  logic [63:0] exp_pc;
  bit          pend;
  bit          pend_taint;
  logic [63:0] pend_addr;
  int          pend_dly;
  ent_t        mq[$];
  logic [63:0] seen[$];
  int          lat_lo = 0;
  int          lat_hi = 0;
  bit          stray  = 1'b0;
  int          idle_run = 0;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_pc     = RESET_PC;
    pend       = 1'b0;
    pend_taint = 1'b0;
    mq.delete();
    idle_run   = 0;
  endtask

  task automatic idle_inputs();
    ifc.redirect    = 1'b0;
    ifc.redirect_pc = 64'h0;
    ifc.imem_gnt    = 1'b0;
    ifc.imem_rvalid = 1'b0;
    ifc.imem_rdata  = 32'h0;
    ifc.inst_ready  = 1'b0;
  endtask

  task automatic check_outputs();
    bit exp_v;
    exp_v = (mq.size() != 0);
    chk1("inst_valid", ifc.inst_valid, exp_v);
    if (exp_v) begin
      chk("PC_out", ifc.PC_out, mq[0].pc);
      chk("inst", 64'(ifc.inst), 64'(mq[0].ins));
    end
    if (ifc.inst_valid) seen.push_back(ifc.PC_out);
    if (ifc.imem_req) begin
      chk("imem_addr", ifc.imem_addr, exp_pc);
      chk1("one_outstanding", pend, 1'b0);
      chk1("req_room", mq.size() < DEPTH, 1'b1);
    end
    if (!ifc.imem_req && !pend && mq.size() < DEPTH) idle_run++;
    else idle_run = 0;
    chk1("req_liveness", idle_run <= 1, 1'b1);
  endtask

  // One clock: drive inputs (memory response comes from the pending model),
  // advance the model at the edge, then check outputs on the falling edge.
  task automatic cycle(input bit redir, input logic [63:0] rpc, input bit gnt, input bit rdy);
    bit rv;
    bit req_s;
    bit do_pop;
    rv = 1'b0;
    if (pend) begin
      if (pend_dly == 0) rv = 1'b1;
      else pend_dly--;
    end
    ifc.redirect    = redir;
    ifc.redirect_pc = rpc;
    ifc.imem_gnt    = gnt;
    ifc.inst_ready  = rdy;
    ifc.imem_rvalid = rv | stray;
    ifc.imem_rdata  = rv ? mem_word(pend_addr) : 32'($urandom());
    req_s = ifc.imem_req;
    @(posedge clk);
    do_pop = !redir && rdy && (mq.size() != 0);
    if (redir) mq.delete();
    else if (do_pop) void'(mq.pop_front());
    if (rv) begin
      if (!pend_taint && !redir) mq.push_back('{pc: pend_addr, ins: mem_word(pend_addr)});
      pend = 1'b0;
    end else if (pend && redir) begin
      pend_taint = 1'b1;
    end
    if (req_s && gnt) begin
      pend       = 1'b1;
      pend_addr  = exp_pc;
      pend_taint = redir;
      pend_dly   = int'($urandom_range(lat_hi, lat_lo));
    end
    if (redir) exp_pc = rpc;
    else if (req_s && gnt) exp_pc = exp_pc + 64'd4;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic wait_req(input bit rdy);
    int n;
    n = 0;
    while (!ifc.imem_req && n < 20) begin
      cycle(1'b0, 64'h0, 1'b0, rdy);
      n++;
    end
    chk1("wait_req_bound", ifc.imem_req, 1'b1);
  endtask

  // Enter at a falling edge; leaves reset released at a falling edge.
  task automatic apply_reset();
    reset = 1'b0;
    idle_inputs();
    model_clear();
    @(negedge clk);
    @(negedge clk);
    chk1("rst_imem_req", ifc.imem_req, 1'b0);
    chk1("rst_inst_valid", ifc.inst_valid, 1'b0);
    chk("rst_inst", 64'(ifc.inst), 64'h0);
    chk("rst_PC_out", ifc.PC_out, 64'h0);
    reset = 1'b1;
    #1;
    chk1("release_idle_no_req", ifc.imem_req, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a0;
    int          n;
    bit          found;
    bit          r;
    logic [63:0] rpc;

    reset = 1'b0;
    idle_inputs();
    model_clear();
    @(negedge clk);

    // zero-wait memory, decode always ready: 0,4,8,C one per two cycles
    apply_reset();
    @(negedge clk);
    lat_lo = 0; lat_hi = 0;
    seen.delete();
    cycle(1'b0, 64'h0, 1'b0, 1'b1);
    chk1("first_req", ifc.imem_req, 1'b1);
    for (int i = 0; i < 9; i++) cycle(1'b0, 64'h0, 1'b1, 1'b1);
    chk("zw_count", 64'(seen.size()), 64'd4);
    chk("zw_pc0", seen[0], 64'h0);
    chk("zw_pc1", seen[1], 64'h4);
    chk("zw_pc2", seen[2], 64'h8);
    chk("zw_pc3", seen[3], 64'hC);

    // decode stalled: two entries held, fetch idles, resumes at 8
    apply_reset();
    @(negedge clk);
    for (int i = 0; i < 8; i++) cycle(1'b0, 64'h0, 1'b1, 1'b0);
    chk1("stall_valid", ifc.inst_valid, 1'b1);
    chk("stall_head", ifc.PC_out, 64'h0);
    chk1("stall_no_req", ifc.imem_req, 1'b0);
    cycle(1'b0, 64'h0, 1'b1, 1'b1);
    chk("stall_second", ifc.PC_out, 64'h4);
    chk1("stall_still_idle", ifc.imem_req, 1'b0);
    cycle(1'b0, 64'h0, 1'b1, 1'b1);
    chk1("stall_drained", ifc.inst_valid, 1'b0);
    chk1("resume_req", ifc.imem_req, 1'b1);
    chk("resume_addr", ifc.imem_addr, 64'h8);

    // redirect while waiting for PC 8: its data is dropped
    apply_reset();
    @(negedge clk);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (ifc.imem_req && ifc.imem_addr == 64'h8) found = 1'b1;
      else cycle(1'b0, 64'h0, 1'b1, 1'b1);
    end
    chk1("reach_pc8", found, 1'b1);
    lat_lo = 2; lat_hi = 2;
    cycle(1'b0, 64'h0, 1'b1, 1'b1);
    cycle(1'b1, 64'h100, 1'b0, 1'b1);
    seen.delete();
    lat_lo = 0; lat_hi = 0;
    for (int i = 0; i < 12; i++) cycle(1'b0, 64'h0, 1'b1, 1'b1);
    chk1("redir_seen_any", seen.size() > 0, 1'b1);
    chk("redir_first_pc", seen[0], 64'h100);
    n = 0;
    foreach (seen[i]) if (seen[i] == 64'h8) n++;
    chk("no_entry_pc8", 64'(n), 64'd0);

    // redirect coinciding with rvalid: buffer flushed, next address 0x200
    cycle(1'b1, 64'h300, 1'b0, 1'b1);
    for (int i = 0; i < 20 && !ifc.inst_valid; i++) cycle(1'b0, 64'h0, 1'b1, 1'b0);
    chk1("refill_valid", ifc.inst_valid, 1'b1);
    chk1("refill_req", ifc.imem_req, 1'b1);
    cycle(1'b0, 64'h0, 1'b1, 1'b0);
    cycle(1'b1, 64'h200, 1'b0, 1'b0);
    chk1("flush_valid", ifc.inst_valid, 1'b0);
    chk1("flush_req", ifc.imem_req, 1'b1);
    chk("flush_addr", ifc.imem_addr, 64'h200);

    // grant withheld five cycles: address stable, advances only after grant
    wait_req(1'b1);
    a0 = ifc.imem_addr;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 64'h0, 1'b0, 1'b1);
      chk1("nogrant_req", ifc.imem_req, 1'b1);
      chk("nogrant_addr", ifc.imem_addr, a0);
    end
    cycle(1'b0, 64'h0, 1'b1, 1'b1);
    wait_req(1'b1);
    chk("after_grant_addr", ifc.imem_addr, a0 + 64'd4);

    // address wrap and unaligned redirect target
    cycle(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b1);
    wait_req(1'b1);
    chk("wrap_addr_hi", ifc.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    cycle(1'b0, 64'h0, 1'b1, 1'b1);
    wait_req(1'b1);
    chk("wrap_addr_zero", ifc.imem_addr, 64'h0);
    cycle(1'b1, 64'h1003, 1'b0, 1'b1);
    wait_req(1'b1);
    chk("unaligned_addr", ifc.imem_addr, 64'h1003);

    // reset asserted while waiting on memory
    for (int i = 0; i < 20 && !ifc.inst_valid; i++) cycle(1'b0, 64'h0, 1'b1, 1'b0);
    wait_req(1'b0);
    lat_lo = 3; lat_hi = 3;
    cycle(1'b0, 64'h0, 1'b1, 1'b0);
    cycle(1'b0, 64'h0, 1'b0, 1'b0);
    chk1("pre_reset_valid", ifc.inst_valid, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk1("async_rst_req", ifc.imem_req, 1'b0);
    chk1("async_rst_valid", ifc.inst_valid, 1'b0);
    chk("async_rst_inst", 64'(ifc.inst), 64'h0);
    chk("async_rst_pc", ifc.PC_out, 64'h0);
    idle_inputs();
    model_clear();
    lat_lo = 0; lat_hi = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    stray = 1'b1;
    cycle(1'b0, 64'h0, 1'b0, 1'b1);
    stray = 1'b0;
    chk1("post_rst_req", ifc.imem_req, 1'b1);
    chk("post_rst_addr", ifc.imem_addr, RESET_PC);
    chk1("late_rvalid_ignored", ifc.inst_valid, 1'b0);

    // random traffic
    apply_reset();
    @(negedge clk);
    lat_lo = 0; lat_hi = 3;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(15, 0) == 0);
      case ($urandom_range(3, 0))
        0:       rpc = 64'hFFFF_FFFF_FFFF_FFF8;
        1:       rpc = {32'($urandom()), 32'($urandom())};
        default: rpc = {32'h0, 32'($urandom()) & 32'hFFFF_FFFC};
      endcase
      cycle(r, rpc, 1'($urandom_range(1, 0)), $urandom_range(9, 0) < 6);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
